// File: rtl/divider_unit.sv
// divider_unit: multi-cycle radix-2 restoring divide/remainder unit for the
// execute stage. Handles signed/unsigned, 64-bit and 32-bit word variants,
// with divide-by-zero and signed-overflow results produced without iterating.

package pipes;

  typedef logic [63:0] word_t;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_DIVU,
    OP_DIVW,
    OP_DIVUW,
    OP_MOD,
    OP_MODU,
    OP_MODW,
    OP_MODUW
  } decode_op_t;

endpackage

module divider_unit
  import pipes::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  decode_op_t op,
  input  word_t      srca,
  input  word_t      srcb,
  input  logic       flush,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output word_t      result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam word_t MIN_DWORD = 64'h8000_0000_0000_0000;
  localparam word_t MIN_WORD  = 64'hFFFF_FFFF_8000_0000;

  state_t     state;
  logic       is_signed;
  logic       is_word;
  logic       is_rem;
  logic       q_neg;
  logic       r_neg;
  logic [6:0] cnt;
  word_t      op_a;
  word_t      op_b;
  word_t      div_q;
  word_t      rem_q;
  word_t      quo_q;

  // Word results are always the sign extension of bit 31, even for unsigned ops.
  function automatic word_t word_ext(input word_t v, input logic word);
    return word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic is_div_op(input decode_op_t o);
    return o inside {OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
                     OP_MOD, OP_MODU, OP_MODW, OP_MODUW};
  endfunction

  logic       accept;
  logic       a_neg;
  logic       b_neg;
  word_t      abs_a;
  word_t      abs_b;
  logic       div_zero;
  logic       overflow;
  word_t      special_val;
  logic [64:0] shifted;
  logic       borrow;
  word_t      diff;
  word_t      q_fin;
  word_t      r_fin;
  word_t      fix_val;

  assign ready = (state == S_IDLE);
  assign accept = valid && ready && !flush && is_div_op(op);
  assign busy = accept || (state inside {S_PREP, S_ITER, S_FIX});

  // Operand conditioning, one restoring step, and final sign fix-up.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    a_neg       = is_signed && op_a[63];
    b_neg       = is_signed && op_b[63];
    abs_a       = a_neg ? (~op_a + 64'd1) : op_a;
    abs_b       = b_neg ? (~op_b + 64'd1) : op_b;
    div_zero    = (op_b == '0);
    overflow    = is_signed && (op_b == '1) &&
                  (op_a == (is_word ? MIN_WORD : MIN_DWORD));
    special_val = '0;
    if (div_zero) special_val = is_rem ? op_a : '1;
    else          special_val = is_rem ? '0 : op_a;
    special_val = word_ext(special_val, is_word);

    // The partial remainder is always below the divisor, so the shifted
    // value fits 65 bits and the kept difference fits 64 bits.
    shifted = {rem_q, quo_q[63]};
    borrow  = (shifted < {1'b0, div_q});
    diff    = shifted[63:0] - div_q;

    q_fin   = q_neg ? (~quo_q + 64'd1) : quo_q;
    r_fin   = r_neg ? (~rem_q + 64'd1) : rem_q;
    fix_val = word_ext(is_rem ? r_fin : q_fin, is_word);
  end

  // Control FSM and datapath registers; flush and reset both return to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values of the others.
    if (reset) begin
      state     <= S_IDLE;
      is_signed <= 1'b0;
      is_word   <= 1'b0;
      is_rem    <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      done      <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            is_signed <= op inside {OP_DIV, OP_DIVW, OP_MOD, OP_MODW};
            is_word   <= op inside {OP_DIVW, OP_DIVUW, OP_MODW, OP_MODUW};
            is_rem    <= op inside {OP_MOD, OP_MODU, OP_MODW, OP_MODUW};
            if (op inside {OP_DIVW, OP_MODW}) begin
              op_a <= {{32{srca[31]}}, srca[31:0]};
              op_b <= {{32{srcb[31]}}, srcb[31:0]};
            end else if (op inside {OP_DIVUW, OP_MODUW}) begin
              op_a <= {32'b0, srca[31:0]};
              op_b <= {32'b0, srcb[31:0]};
            end else begin
              op_a <= srca;
              op_b <= srcb;
            end
            state <= S_PREP;
          end
        end
        S_PREP: begin
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          div_q <= abs_b;
          rem_q <= '0;
          // Word magnitudes fit in 32 bits; park them at the top so only
          // 32 shifts are needed.
          quo_q <= is_word ? {abs_a[31:0], 32'b0} : abs_a;
          cnt   <= is_word ? 7'd32 : 7'd64;
          if (div_zero || overflow) begin
            result <= special_val;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= borrow ? shifted[63:0] : diff;
          quo_q <= {quo_q[62:0], ~borrow};
          cnt   <= cnt - 7'd1;
          if (cnt == 7'd1) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed testbench for divider_unit: hand-computed results and done latency
// for signed/unsigned, word, special-case, flush, reset and back-to-back traffic.

module tb_divider_unit;
  import pipes::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  decode_op_t op;
  word_t      srca;
  word_t      srcb;
  logic       flush;
  logic       ready;
  logic       busy;
  logic       done;
  word_t      result;

  int checks = 0;
  int failures = 0;

  localparam int TIMEOUT = 200;

  divider_unit dut (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .op     (op),
    .srca   (srca),
    .srcb   (srcb),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Issue one request at a negedge, return the cycle index (relative to the
  // accept edge) at which done was seen and the result in that cycle.
  task automatic run_op(input decode_op_t o, input word_t a, input word_t b,
                        output word_t res, output int cyc);
    valid = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    srca  = '0;
    srcb  = '0;
    cyc   = 1;
    while (!done && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, busy, done} !== 3'b100 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset_state ready/busy/done=%b result=%h want 100/0",
               {ready, busy, done}, result);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_signed();
    word_t r; int c;
    run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, c);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD || c !== 67) begin
      failures++;
      $display("FAIL div_signed result=%h cycle=%0d want FFFFFFFFFFFFFFFD/67", r, c);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL div_signed_after done=%b ready=%b want 0/1", done, ready);
    end
    run_op(OP_MOD, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF || c !== 67) begin
      failures++;
      $display("FAIL mod_signed result=%h cycle=%0d want FFFFFFFFFFFFFFFF/67", r, c);
    end
  endtask

  task automatic test_div_unsigned();
    word_t r; int c;
    run_op(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'h0FFF_FFFF_FFFF_FFFF || c !== 67) begin
      failures++;
      $display("FAIL divu_big result=%h cycle=%0d want 0FFFFFFFFFFFFFFF/67", r, c);
    end
    run_op(OP_MODU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'hF || c !== 67) begin
      failures++;
      $display("FAIL modu_big result=%h cycle=%0d want F/67", r, c);
    end
  endtask

  task automatic test_div_by_zero();
    word_t r; int c;
    run_op(OP_DIVU, 64'h1234, 64'd0, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF || c !== 2) begin
      failures++;
      $display("FAIL divu_zero result=%h cycle=%0d want FFFFFFFFFFFFFFFF/2", r, c);
    end
    run_op(OP_MODU, 64'h1234, 64'd0, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'h1234 || c !== 2) begin
      failures++;
      $display("FAIL modu_zero result=%h cycle=%0d want 1234/2", r, c);
    end
  endtask

  task automatic test_overflow();
    word_t r; int c;
    run_op(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'h8000_0000_0000_0000 || c !== 2) begin
      failures++;
      $display("FAIL div_overflow result=%h cycle=%0d want 8000000000000000/2", r, c);
    end
    run_op(OP_MOD, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'd0 || c !== 2) begin
      failures++;
      $display("FAIL mod_overflow result=%h cycle=%0d want 0/2", r, c);
    end
  endtask

  task automatic test_word();
    word_t r; int c;
    run_op(OP_DIVUW, 64'hDEAD_0000_FFFF_FFFE, 64'd2, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'h0000_0000_7FFF_FFFF || c !== 35) begin
      failures++;
      $display("FAIL divuw result=%h cycle=%0d want 000000007FFFFFFF/35", r, c);
    end
    run_op(OP_MODW, 64'h0000_0000_FFFF_FFF9, 64'd2, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF || c !== 35) begin
      failures++;
      $display("FAIL modw result=%h cycle=%0d want FFFFFFFFFFFFFFFF/35", r, c);
    end
  endtask

  // Follows test_word, so the held result is FFFF_FFFF_FFFF_FFFF.
  task automatic test_flush();
    word_t r; int c;
    bit saw_done;
    saw_done = 1'b0;
    valid = 1'b1; op = OP_DIV; srca = 64'd100; srcb = 64'd7;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k < 20; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;               // flush high during cycle 20
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (saw_done || done !== 1'b0 || ready !== 1'b1 ||
        result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++;
      $display("FAIL flush_abort saw_done=%b done=%b ready=%b result=%h want 0/0/1/FFFFFFFFFFFFFFFF",
               saw_done, done, ready, result);
    end
    run_op(OP_DIVU, 64'd100, 64'd7, r, c);
    @(negedge clk);
    checks++;
    if (r !== 64'd14 || c !== 67) begin
      failures++;
      $display("FAIL flush_reaccept result=%h cycle=%0d want e/67", r, c);
    end
    valid = 1'b1; flush = 1'b1; op = OP_DIVU; srca = 64'd9; srcb = 64'd0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid_busy busy=%b want 0", busy);
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 64'd14) begin
      failures++;
      $display("FAIL flush_valid_ignored ready=%b done=%b result=%h want 1/0/e",
               ready, done, result);
    end
  endtask

  // Follows test_flush, so the held result is 14 before reset clears it.
  task automatic test_reset_mid();
    valid = 1'b1; op = OP_DIVU; srca = 64'd1000; srcb = 64'd3;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid ready/busy/done=%b result=%h want 100/0",
               {ready, busy, done}, result);
    end
    repeat (70) begin
      @(negedge clk);
      if (done) begin
        checks++;
        failures++;
        $display("FAIL reset_mid_done done=1 want 0");
      end
    end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; op = OP_DIVU; srca = 64'h1234; srcb = 64'd0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept_busy busy=%b want 1", busy);
    end
    @(posedge clk);             // edge 0: first accept
    @(negedge clk);             // cycle 1
    op = OP_MODU;               // valid stays high
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_cycle1 ready=%b busy=%b want 0/1", ready, busy);
    end
    @(negedge clk);             // cycle 2
    checks++;
    if (done !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 ||
        result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++;
      $display("FAIL b2b_cycle2 done=%b ready=%b busy=%b result=%h want 1/0/0/FFFFFFFFFFFFFFFF",
               done, ready, busy, result);
    end
    @(negedge clk);             // cycle 3: second accept
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_cycle3 done=%b ready=%b busy=%b want 0/1/1", done, ready, busy);
    end
    @(negedge clk);             // cycle 4
    valid = 1'b0;
    checks++;
    if (done !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_cycle4 done=%b ready=%b want 0/0", done, ready);
    end
    @(negedge clk);             // cycle 5
    checks++;
    if (done !== 1'b1 || result !== 64'h1234) begin
      failures++;
      $display("FAIL b2b_cycle5 done=%b result=%h want 1/1234", done, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_after done=%b ready=%b want 0/1", done, ready);
    end
  endtask

  task automatic test_non_div_op();
    valid = 1'b1; op = OP_ADD; srca = 64'd5; srcb = 64'd0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL nondiv_busy busy=%b want 0", busy);
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nondiv_idle ready=%b busy=%b want 1/0", ready, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 64'h1234) begin
      failures++;
      $display("FAIL nondiv_no_done done=%b result=%h want 0/1234", done, result);
    end
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    op    = OP_NOP;
    srca  = '0;
    srcb  = '0;
    flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_div_signed();
    test_div_unsigned();
    test_div_by_zero();
    test_overflow();
    test_word();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_non_div_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
# divider_unit

Multi-cycle integer divide/remainder unit in the execute stage, directly downstream of the decode operand-select logic. It takes the `srca`/`srcb` pair and `decode_op_t` op produced in decode and executes DIV, DIVU, DIVW, DIVUW, MOD, MODU, MODW and MODUW with a radix-2 restoring algorithm. It raises `busy` so the pipeline control can stall the front end. It returns a 64-bit result with a one-cycle `done` pulse.

## Interface
Parameters:
- none; the data width is fixed at 64 (`word_t`) and the opcode type comes from `pipes::decode_op_t`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  request present; accepted when `valid && ready && !flush`.
- `op`  in  decode_op_t  operation, sampled on accept.
- `srca`  in  64  dividend, sampled on accept.
- `srcb`  in  64  divisor, sampled on accept.
- `flush`  in  1  abort; kills any in-flight operation.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in PREP, ITER and FIX; high in the accept cycle too (combinational from `valid && ready && !flush`).
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  64  quotient or remainder; holds its value until the next `done`.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- **IDLE → PREP on accept.** Latch:
  - `signed` = DIV/DIVW/MOD/MODW.
  - `word` = *W ops.
  - `rem` = MOD*.
  - Operands. For word ops use `srca[31:0]`/`srcb[31:0]`, sign- or zero-extended per `signed`.
- **PREP** (1 cycle):
  - Record the quotient sign (`a_neg ^ b_neg`) and the remainder sign (`a_neg`).
  - Take absolute values when signed.
  - Load the counter with N = 64 (word = 0) or 32 (word = 1).
  - Detect special cases:
    - Divisor zero: quotient = all ones; remainder = dividend (the original operand, after word truncation).
    - Signed overflow, i.e. dividend = most-negative (64- or 32-bit) and divisor = −1: quotient = dividend, remainder = 0.
  - Special case → DONE with `result` loaded directly; otherwise → ITER.
- **ITER** (N cycles): one restoring step per cycle.
  - Shift `{R,Q}` left 1 bit.
  - Trial-subtract the divisor from R (65-bit compare).
  - On no borrow, keep the difference and set the Q LSB.
  - Counter decrements; at counter = 1, → FIX.
- **FIX** (1 cycle):
  - Negate Q if the quotient sign is set; negate R if the remainder sign is set.
  - Select R when `rem`, else Q.
  - For word ops, sign-extend bit 31 to 64 bits. This applies to DIVUW/MODUW too.
  - Register into `result`; → DONE.
- **DONE** (1 cycle): `done` = 1; → IDLE unconditionally.
- **Flush:** in any state, `flush` forces IDLE on the next edge.
  - No `done` is produced and `result` is unchanged.
  - `flush` with `valid` in IDLE: the request is not accepted.
- **Reset:** same as flush, plus all outputs and registers are cleared. Reset mid-operation discards the operation.
- **Non-divide op with `valid`:** ignored; stays in IDLE with `ready` = 1.

## Timing
- Reset values: `ready` = 1, `busy` = 0, `done` = 0, `result` = 0, state = IDLE.
- Accept at edge 0. PREP occupies cycle 1.
- Normal 64-bit op: ITER cycles 2–65, FIX cycle 66, `done` in cycle 67.
- Normal word op: `done` in cycle 35.
- Special case: `done` in cycle 2.
- `ready` returns in the cycle after `done`; earliest back-to-back accept is that cycle (throughput N + 4 for normal ops).
- Inputs are ignored after accept; the decode stage may change them freely.
- `done` is never high in two consecutive cycles.

## Test plan
- **DIV, signed.** `srca` = −7 (0xFFFF_FFFF_FFFF_FFF9), `srcb` = 2 → `result` = 0xFFFF_FFFF_FFFF_FFFD (−3), `done` in cycle 67. MOD on the same operands → 0xFFFF_FFFF_FFFF_FFFF (−1).
- **DIVU by zero.** `srca` = 0x1234, `srcb` = 0 → 0xFFFF_FFFF_FFFF_FFFF, `done` in cycle 2. MODU on the same operands → 0x1234.
- **DIV overflow.** `srca` = 0x8000_0000_0000_0000, `srcb` = −1 → 0x8000_0000_0000_0000, `done` in cycle 2. MOD on the same operands → 0.
- **DIVUW.** `srca` = 0xDEAD_0000_FFFF_FFFE, `srcb` = 2 → 0x0000_0000_7FFF_FFFF, `done` in cycle 35. MODW with `srca` = 0x0000_0000_FFFF_FFF9, `srcb` = 2 → 0xFFFF_FFFF_FFFF_FFFF.
- **Flush.**
  - Accept DIV 100/7, assert `flush` in cycle 20 → IDLE in cycle 21, no `done`, `result` unchanged.
  - Immediately accept DIVU 100/7 → 14 in cycle 67 after that accept.
  - Additionally, with `valid` and `flush` in the same cycle in IDLE, the request is not accepted.
- **Reset and ready.**
  - Assert `reset` mid-ITER → all outputs at reset values the next cycle.
  - `valid` held high while busy → no second accept until the cycle after `done`.
